// File: rtl/search_pkg.sv
// Shared definitions for the pattern-search slice: loader state encoding,
// symbol/address widths and the RAM read/write strobe encoding.
package search_pkg;

  localparam int unsigned DW = 3;  // symbol width, equals RAM data width
  localparam int unsigned AW = 6;  // RAM address width

  // ram_rw encoding, shared with the symbol RAM and the search control
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/start_watchdog.sv
// Watches the engine's searching flag while the loader waits for a search.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   active       loader is in WAIT; counter and seen flag are held clear otherwise
//   sch          engine searching flag
//   timeout      this is the START_TIMEOUT-th WAIT cycle and sch never rose
//   sch_fall     sch was seen high earlier and is low now (search finished)
module start_watchdog #(
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic sch,
  output logic timeout,
  output logic sch_fall
);

  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] LastCnt = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] SatCnt  = CW'(START_TIMEOUT);

  if (START_TIMEOUT < 1) begin : g_bad_timeout
    $error("start_watchdog: START_TIMEOUT must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;

  always_comb begin
    cnt_d  = '0;
    seen_d = 1'b0;
    if (active) begin
      cnt_d  = (cnt_q == SatCnt) ? cnt_q : cnt_q + 1'b1;
      seen_d = seen_q | sch;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  // cnt_q counts completed WAIT cycles, so WAIT lasts START_TIMEOUT cycles at most.
  // An sch rising in the final cycle still counts as a start.
  assign timeout  = active && !seen_q && !sch && (cnt_q >= LastCnt);
  assign sch_fall = active && seen_q && !sch;

endmodule

// File: rtl/search_loader.sv
// Upstream feeder for the pattern-search engine. Accepts DEPTH symbols from a
// valid/ready stream, writes them to the symbol RAM at addresses 0..DEPTH-1,
// pulses shstr, then follows the engine's sch flag until done, timeout or abort.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   load_req, abort            run control
//   in_valid, in_data, in_ready  symbol stream
//   ram_rw, ram_addr, ram_data   registered RAM write port
//   shstr, sch                 search start pulse / engine searching flag
//   load_count, busy, done, error  status
module search_loader #(
  parameter int unsigned DW            = search_pkg::DW,
  parameter int unsigned AW            = search_pkg::AW,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          shstr,
  input  logic          sch,
  output logic [AW:0]   load_count,
  output logic          busy,
  output logic          done,
  output logic          error
);

  import search_pkg::*;

  localparam int unsigned CntW = AW + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
    $error("search_loader: DEPTH must be in 1..2**AW");
  end

  state_e        state_q, state_d;
  // Doubles as the write pointer: both clear on load_req and step on each accept.
  logic [AW:0]   cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          timeout, sch_fall;

  start_watchdog #(
    .START_TIMEOUT(START_TIMEOUT)
  ) u_start_watchdog (
    .clk      (clk),
    .reset    (reset),
    .active   (state_q == ST_WAIT),
    .sch      (sch),
    .timeout  (timeout),
    .sch_fall (sch_fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = RW_READ;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    if (abort && state_q != ST_IDLE) begin
      // A beat accepted in the abort cycle is dropped: no write, no count.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            rw_d   = RW_WRITE;
            addr_d = cnt_q[AW-1:0];
            data_d = in_data;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LastBeat) state_d = ST_START;
          end
        end
        ST_START: state_d = ST_WAIT;
        ST_WAIT: begin
          if (sch_fall) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (timeout) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign shstr      = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign ram_rw     = rw_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign load_count = cnt_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_search_loader.sv
// Bench for search_loader (DEPTH=4, START_TIMEOUT=15): directed runs with literal
// expectations, then random stimulus, all checked every cycle against a run-level
// reference model.
module tb_search_loader;

  localparam int DW = 3;
  localparam int AW = 6;
  localparam int DEPTH = 4;
  localparam int TMO = 15;

  // Model phases of a load run.
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_START = 2;
  localparam int P_WAIT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_req = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          shstr;
  logic          sch = 1'b0;
  logic [AW:0]   load_count;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  search_loader #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .START_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data(ram_data),
    .shstr(shstr), .sch(sch), .load_count(load_count), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the run, beats taken, cycles spent waiting for the engine.
  int m_phase, m_beats, m_waited;
  bit m_seen, m_rw, m_done, m_err;
  int m_addr, m_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_IDLE; m_beats <= 0; m_waited <= 0; m_seen <= 0;
      m_rw <= 0; m_done <= 0; m_err <= 0; m_addr <= 0; m_data <= 0;
    end else begin
      m_rw <= 0; m_done <= 0; m_err <= 0;
      if (abort && m_phase != P_IDLE) begin
        m_phase <= P_IDLE;
      end else if (m_phase == P_IDLE) begin
        if (load_req) begin m_phase <= P_LOAD; m_beats <= 0; end
      end else if (m_phase == P_LOAD) begin
        if (in_valid) begin
          m_rw <= 1; m_addr <= m_beats; m_data <= int'(in_data);
          m_beats <= m_beats + 1;
          if (m_beats + 1 == DEPTH) m_phase <= P_START;
        end
      end else if (m_phase == P_START) begin
        m_phase <= P_WAIT; m_waited <= 0; m_seen <= 0;
      end else begin
        if (m_seen && !sch) begin
          m_phase <= P_IDLE; m_done <= 1;
        end else if (!m_seen && !sch && m_waited + 1 >= TMO) begin
          m_phase <= P_IDLE; m_err <= 1;
        end else begin
          m_waited <= m_waited + 1;
          if (sch) m_seen <= 1;
        end
      end
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_phase == P_LOAD);
    chk("shstr", shstr, m_phase == P_START);
    chk("busy", busy, m_phase != P_IDLE);
    chk("ram_rw", ram_rw, m_rw);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_data", ram_data, m_data);
    chk("load_count", load_count, m_beats);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("done_error_excl", done && error, 0);
  end

  // Drive inputs for one cycle, then return 1 time unit after the edge that used them.
  task automatic step(input logic li, input logic ab, input logic v,
                      input logic [DW-1:0] d, input logic s);
    load_req = li; abort = ab; in_valid = v; in_data = d; sch = s;
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] syms [4];
  int got;

  initial begin
    syms[0] = 3'd5; syms[1] = 3'd2; syms[2] = 3'd7; syms[3] = 3'd1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_count", load_count, 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load of 5,2,7,1.
    step(1, 0, 0, 0, 0);
    chk("lit_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, syms[i], 0);
      chk("lit_rw", ram_rw, 1);
      chk("lit_addr", ram_addr, i);
      chk("lit_data", ram_data, syms[i]);
    end
    chk("lit_shstr", shstr, 1);
    chk("lit_count4", load_count, 4);
    chk("lit_ready_drop", in_ready, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_shstr_once", shstr, 0);

    // Search runs 10 cycles then completes.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("lit_done", done, 1);
    chk("lit_done_busy", busy, 0);
    chk("lit_done_err", error, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_done_pulse", done, 0);

    // Gapped stream, then start timeout.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, (i % 2) == 0, 3'($urandom), 0);
      chk("lit_gap_rw", ram_rw, (i % 2) == 0);
      if ((i % 2) == 0) chk("lit_gap_addr", ram_addr, i / 2);
    end
    chk("lit_gap_start", shstr, 1);
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, 0, 0);
      if (error) begin got = k; break; end
    end
    chk("lit_timeout_cycles", got, 16);
    chk("lit_timeout_idle", busy, 0);
    chk("lit_timeout_done", done, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_error_pulse", error, 0);

    // Abort on the third accepted beat.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3'd3, 0);
    step(0, 0, 1, 3'd4, 0);
    step(0, 1, 1, 3'd6, 0);
    chk("lit_abort_ready", in_ready, 0);
    chk("lit_abort_rw", ram_rw, 0);
    chk("lit_abort_count", load_count, 2);
    chk("lit_abort_busy", busy, 0);
    step(0, 0, 0, 0, 1);
    chk("lit_abort_quiet", shstr | done | error, 0);

    // Asynchronous reset between edges mid-load.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3'd2, 0);
    step(0, 0, 1, 3'd5, 0);
    #2 reset = 1'b0;
    #1;
    chk("lit_arst_busy", busy, 0);
    chk("lit_arst_rw", ram_rw, 0);
    chk("lit_arst_addr", ram_addr, 0);
    chk("lit_arst_data", ram_data, 0);
    chk("lit_arst_count", load_count, 0);
    chk("lit_arst_ready", in_ready, 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3'd6, 0);
    chk("lit_restart_addr", ram_addr, 0);
    chk("lit_restart_data", ram_data, 6);
    chk("lit_restart_count", load_count, 1);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic s;
      s = sch;
      if ($urandom_range(0, 99) < 12) s = ~s;
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 60, 3'($urandom), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
